// File: rtl/rst_seq_ctrl.sv
// Reset-tree sequencer: holds every domain in reset, then releases stages one by one.
// Optional watchdog re-sequencing is built only when RST_SEQ_WDT_EN is defined.
module rst_seq_ctrl #(
    parameter int unsigned N_STAGES  = 4,
    parameter int unsigned HOLD_CYC  = 4,
    parameter int unsigned STAGE_DLY = 8,
    parameter int unsigned WDT_CYC   = 64
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                sw_rst_req_i,
    output logic                sw_rst_ack_o,
    input  logic                heartbeat_i,
    output logic [N_STAGES-1:0] stage_rst_no,
    output logic                busy_o,
    output logic                done_o,
    output logic                wdt_fire_o
);

    localparam int unsigned MaxHd  = (HOLD_CYC > STAGE_DLY) ? HOLD_CYC : STAGE_DLY;
    localparam int unsigned MaxCyc = (MaxHd > WDT_CYC) ? MaxHd : WDT_CYC;
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);

    localparam logic [CntW-1:0]     HoldEnd    = CntW'(HOLD_CYC);
    localparam logic [CntW-1:0]     DlyEnd     = CntW'(STAGE_DLY - 1);
    localparam logic [N_STAGES-1:0] StageFirst = N_STAGES'(1);

    typedef enum logic [1:0] {
        StAssert,
        StRelease,
        StDone,
        StAck
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [N_STAGES-1:0] stage_q, stage_d;
    logic                pend_q, pend_d;
    logic                fire_d;

`ifdef RST_SEQ_WDT_EN
    localparam logic [CntW-1:0] WdtEnd = CntW'(WDT_CYC - 1);

    logic fire_q;
    logic wdt_expire;

    // A heartbeat in the expiry cycle wins over the watchdog.
    assign wdt_expire = !heartbeat_i && (cnt_q == WdtEnd);
`else
    logic unused_heartbeat;
    assign unused_heartbeat = heartbeat_i;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        pend_d  = pend_q;
        fire_d  = 1'b0;

        unique case (state_q)
            StAssert: begin
                stage_d = '0;
                if (cnt_q == HoldEnd) begin
                    state_d = StRelease;
                    cnt_d   = '0;
                    stage_d = StageFirst;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StRelease: begin
                // Leave one cycle after the last stage goes high.
                if (&stage_q) begin
                    state_d = pend_q ? StAck : StDone;
                    pend_d  = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q == DlyEnd) begin
                    stage_d = (stage_q << 1) | StageFirst;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StDone: begin
`ifdef RST_SEQ_WDT_EN
                // Expiry takes priority; a held request is picked up after the re-sequence.
                if (wdt_expire) begin
                    state_d = StAssert;
                    cnt_d   = '0;
                    stage_d = '0;
                    fire_d  = 1'b1;
                end else if (sw_rst_req_i) begin
                    state_d = StAssert;
                    cnt_d   = '0;
                    stage_d = '0;
                    pend_d  = 1'b1;
                end else if (heartbeat_i) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`else
                if (sw_rst_req_i) begin
                    state_d = StAssert;
                    cnt_d   = '0;
                    stage_d = '0;
                    pend_d  = 1'b1;
                end
`endif
            end

            StAck: begin
                if (!sw_rst_req_i) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = StAssert;
                cnt_d   = '0;
                stage_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StAssert;
            cnt_q   <= '0;
            stage_q <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            pend_q  <= pend_d;
        end
    end

`ifdef RST_SEQ_WDT_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fire_q <= 1'b0;
        end else begin
            fire_q <= fire_d;
        end
    end

    assign wdt_fire_o = fire_q;
`else
    logic unused_fire;
    assign unused_fire = fire_d;
    assign wdt_fire_o  = 1'b0;
`endif

    assign stage_rst_no = stage_q;
    assign busy_o       = (state_q == StAssert) || (state_q == StRelease);
    assign done_o       = (state_q == StDone) || (state_q == StAck);
    assign sw_rst_ack_o = (state_q == StAck);

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: expectations are keyed by absolute clock edge.
// Build with RST_SEQ_WDT_EN defined to exercise the watchdog instead of the disabled-build check.
module tb_rst_seq_ctrl;

    typedef struct {
        int         cyc;
        string      name;
        logic [3:0] stage;
        logic       busy;
        logic       done;
        logic       ack;
        logic       fire;
    } exp_t;

`ifdef RST_SEQ_WDT_EN
    localparam int ExpFires = 2;
`else
    localparam int ExpFires = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req;
    logic       hb;
    logic       ack;
    logic [3:0] stage;
    logic       busy;
    logic       done;
    logic       fire;

    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   fire_cnt = 0;
    logic fin_req  = 1'b0;
    logic fin_done = 1'b0;
    exp_t exp_q[$];

    rst_seq_ctrl #(
        .N_STAGES (4),
        .HOLD_CYC (4),
        .STAGE_DLY(8),
        .WDT_CYC  (64)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .sw_rst_req_i(req),
        .sw_rst_ack_o(ack),
        .heartbeat_i (hb),
        .stage_rst_no(stage),
        .busy_o      (busy),
        .done_o      (done),
        .wdt_fire_o  (fire)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            edge_cnt <= edge_cnt + 1;
        end
    end

    task automatic expect_at(input int cyc, input string name, input logic [3:0] st,
                             input logic b, input logic d, input logic a, input logic f);
        exp_t e;
        int   i;
        e.cyc   = cyc;
        e.name  = name;
        e.stage = st;
        e.busy  = b;
        e.done  = d;
        e.ack   = a;
        e.fire  = f;
        i = 0;
        while (i < exp_q.size() && exp_q[i].cyc <= cyc) i++;
        exp_q.insert(i, e);
    endtask

    // Full release sequence; base is the edge that first sees ASSERT with a cleared counter.
    task automatic push_seq(input int base, input logic a);
        expect_at(base + 3,  "hold",   4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_at(base + 4,  "stage0", 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_at(base + 11, "pre1",   4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_at(base + 12, "stage1", 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_at(base + 19, "pre2",   4'b0011, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_at(base + 20, "stage2", 4'b0111, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_at(base + 27, "pre3",   4'b0111, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_at(base + 28, "stage3", 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_at(base + 29, "done",   4'b1111, 1'b0, 1'b1, a,    1'b0);
    endtask

    task automatic wait_edge(input int n);
        while (edge_cnt < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compares every expectation due at the current edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (fire === 1'b1) fire_cnt++;
            while (exp_q.size() > 0 && exp_q[0].cyc <= edge_cnt) begin
                e = exp_q.pop_front();
                n_checks++;
                if (e.cyc != edge_cnt) begin
                    $display("FAIL %s: due at edge %0d, reached at edge %0d",
                             e.name, e.cyc, edge_cnt);
                end else if ({stage, busy, done, ack, fire} !==
                             {e.stage, e.busy, e.done, e.ack, e.fire}) begin
                    $display({"FAIL %s edge %0d: got stage=%b busy=%b done=%b ack=%b fire=%b,",
                              " expected stage=%b busy=%b done=%b ack=%b fire=%b"},
                             e.name, edge_cnt, stage, busy, done, ack, fire,
                             e.stage, e.busy, e.done, e.ack, e.fire);
                end else begin
                    n_pass++;
                end
            end
            if (fin_req && !fin_done) begin
                n_checks++;
                if (fire_cnt != ExpFires)
                    $display("FAIL fire_count: got %0d pulses, expected %0d", fire_cnt, ExpFires);
                else
                    n_pass++;
                n_checks++;
                if (exp_q.size() != 0)
                    $display("FAIL drain: %0d expectations never reached, expected 0",
                             exp_q.size());
                else
                    n_pass++;
                fin_done = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation stuck at edge %0d, expected to finish", edge_cnt);
        $fatal(1, "time limit expired");
    end

    initial begin
        int base;
        rst_n = 1'b0;
        req   = 1'b0;
        hb    = 1'b0;

        // Power-on release
        expect_at(2, "por_reset", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_edge(3);
        rst_n = 1'b1;
        base  = 4;
        push_seq(base, 1'b0);
        wait_edge(33);

        // Software reset from DONE
        req = 1'b1;
        expect_at(34, "sw_enter", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        push_seq(35, 1'b1);
        wait_edge(67);
        expect_at(68, "ack_hold", 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_edge(68);
        req = 1'b0;
        expect_at(69, "ack_drop", 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_at(70, "idle",     4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_edge(70);

        // Request raised mid-sequence is held off until DONE
        rst_n = 1'b0;
        expect_at(72, "rst2", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_edge(72);
        rst_n = 1'b1;
        base  = 73;
        push_seq(base, 1'b0);
        wait_edge(base + 9);
        req = 1'b1;
        expect_at(base + 30, "late_enter", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        push_seq(base + 31, 1'b1);
        wait_edge(133);
        expect_at(134, "late_ack", 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_edge(134);
        req = 1'b0;
        expect_at(135, "late_drop", 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_edge(135);

        // Reset asserted mid-sequence
        rst_n = 1'b0;
        expect_at(136, "rst3", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_edge(136);
        rst_n = 1'b1;
        base  = 137;
        expect_at(base + 4,  "mid_s0", 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_at(base + 14, "mid_s1", 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_edge(base + 14);
        rst_n = 1'b0;
        expect_at(base + 15, "mid_rst", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_edge(base + 16);
        rst_n = 1'b1;
        push_seq(154, 1'b0);
        wait_edge(183);

        // Reset during a software sequence discards the pending ack
        req = 1'b1;
        expect_at(184, "sw2_enter", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_at(193, "sw2_s0",    4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_edge(193);
        req   = 1'b0;
        rst_n = 1'b0;
        expect_at(194, "sw2_rst", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_edge(194);
        rst_n = 1'b1;
        push_seq(195, 1'b0);
        expect_at(226, "no_ack", 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_edge(226);

`ifdef RST_SEQ_WDT_EN
        // Heartbeat exactly at the expiry edge suppresses the fire
        expect_at(288, "hb_save",  4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_at(289, "hb_after", 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_edge(287);
        hb = 1'b1;
        wait_edge(288);
        hb = 1'b0;
        expect_at(351, "wdt_pre",  4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_at(352, "wdt_fire", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
        expect_at(353, "wdt_post", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        push_seq(353, 1'b0);
        wait_edge(445);

        // Request coincides with expiry: fire first, request serviced afterwards
        req = 1'b1;
        expect_at(446, "wdt_req_fire", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
        push_seq(447, 1'b0);
        expect_at(477, "wdt_req_enter", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        push_seq(478, 1'b1);
        wait_edge(507);
        req = 1'b0;
        expect_at(508, "wdt_req_drop", 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);

        // Heartbeat every 50 cycles keeps the watchdog quiet
        expect_at(572, "hb_50a", 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_at(636, "hb_50b", 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_at(700, "hb_50c", 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_at(800, "hb_50d", 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            wait_edge(508 + 50 * i - 1);
            hb = 1'b1;
            wait_edge(508 + 50 * i);
            hb = 1'b0;
        end
        wait_edge(800);
`else
        // Watchdog absent: DONE holds for 1000 cycles without heartbeat
        expect_at(290,  "nowdt_a", 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_at(500,  "nowdt_b", 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_at(1000, "nowdt_c", 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_at(1226, "nowdt_d", 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_edge(1226);
`endif

        repeat (2) @(posedge clk);
        fin_req = 1'b1;
        for (int i = 0; i < 10 && !fin_done; i++) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
